fp_normalize_round: RTL and testbench

Multi-cycle normalise-and-round stage of the single-precision float adder. It accepts the raw signed-magnitude sum from the mantissa add/subtract stage: sign, biased exponent and 27-bit extended mantissa. It then:
- shifts the mantissa one bit per cycle until normalised,
- rounds to nearest-even,
- packs an IEEE-754 word.

The packed word feeds the adder's registered result-select stage. Special operands (NaN/Inf inputs) are resolved before this stage and never enter it.

---
 rtl/fp_normalize_round.sv | 176 +++++++++++++++++
 tb/tb_fp_normalize_round.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
// Multi-cycle normalise-and-round stage of the binary32 adder. It takes the
// signed-magnitude sum from the mantissa add/sub stage. The mantissa is shifted
// one bit per cycle until the hidden bit is set (or the exponent reaches the
// denormal floor). The result is then rounded to nearest-even and packed into
// an IEEE-754 word.
//
// Ports
//   clk        in   clock, rising edge
//   res        in   asynchronous active-low reset
//   in_valid   in   operand present (taken only while in_ready=1)
//   in_ready   out  high only while idle
//   sign_in    in   result sign
//   exp_in     in   biased exponent, 1..254
//   mant_in    in   [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
//   out_valid  out  one-cycle pulse, result/ovf/unf valid while high
//   result     out  packed {sign, exp[7:0], frac[22:0]}
//   ovf        out  result rounded to infinity
//   unf        out  denormal (or zero) result from a non-zero input
// -----------------------------------------------------------------------------
module fp_normalize_round (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [26:0] mant_in,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic [8:0]  e_q, e_d;
  logic [26:0] m_q, m_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic        round_up_s;
  logic [24:0] r_s;
  logic [8:0]  e_rnd_s;

  // Rounding datapath, always computed from the current mantissa
  always_comb begin
    // nearest-even: round up on guard when sticky or the LSB makes it odd
    round_up_s = m_q[1] & (m_q[0] | m_q[2]);
    r_s        = {1'b0, m_q[25:2]} + {24'd0, round_up_s};
    // a carry out of the rounded significand bumps the exponent
    e_rnd_s    = e_q + {8'd0, r_s[24]};
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e_d         = e_q;
    m_d         = m_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = sign_in;
          e_d     = {1'b0, exp_in};
          m_d     = mant_in;
          state_d = NORM;
        end else begin
          state_d = IDLE;
        end
      end

      NORM: begin
        if (m_q == 27'd0) begin
          state_d = ROUND;
        end else if (m_q[26]) begin
          // fold the bit shifted out into sticky so rounding stays exact
          m_d = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
          e_d = e_q + 9'd1;
        end else if (m_q[25]) begin
          state_d = ROUND;
        end else if (e_q == 9'd1) begin
          // exponent floor reached: leave it as a denormal
          state_d = ROUND;
        end else begin
          m_d = {m_q[25:0], 1'b0};
          e_d = e_q - 9'd1;
        end
      end

      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        e_d         = e_rnd_s;
        if (m_q == 27'd0) begin
          // a zero mantissa can only come from a zero input
          result_d = {s_q, 31'd0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (!m_q[25]) begin
          // denormal path: e is 1 here; rounding may promote to the smallest normal
          result_d = {s_q, 7'd0, r_s[23], r_s[22:0]};
          ovf_d    = 1'b0;
          unf_d    = ~r_s[23];
        end else if (e_rnd_s >= 9'd255) begin
          result_d = {s_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else begin
          // on a rounding carry r_s[22:0] is already zero
          result_d = {s_q, e_rnd_s[7:0], r_s[22:0]};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= 9'd0;
      m_q         <= 27'd0;
      result_q    <= 32'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      m_q         <= m_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// -----------------------------------------------------------------------------
// Testbench for fp_normalize_round: directed cases plus randomized operands.
// The expected word, flags and latency come from an arithmetic reference model
// and are queued at issue time; a monitor pops them on each out_valid.
// -----------------------------------------------------------------------------
module tb_fp_normalize_round;

  logic        clk;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [26:0] mant_in;
  logic        out_valid;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  fp_normalize_round dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  logic prev_ov = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: normalise by counting leading zeros, then round-half-even on integers
  function automatic exp_t ref_model(input logic sg, input logic [7:0] ex, input logic [26:0] mn);
    exp_t        r;
    logic [63:0] m;
    logic [63:0] q;
    int          e;
    int          msb;
    int          sh;
    logic        g, st, up;
    m = 64'(mn);
    e = int'(ex);
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.lat = 2;
    r.cap = 0;
    if (m == 64'd0) begin
      r.res = {sg, 31'd0};
      return r;
    end
    if (m >= 64'd67108864) begin
      m = (m >> 1) | (m & 64'd1);
      e = e + 1;
      r.lat = r.lat + 1;
    end else begin
      msb = 0;
      for (int i = 0; i < 27; i++) if (((m >> i) & 64'd1) != 64'd0) msb = i;
      sh = 25 - msb;
      if (sh > e - 1) sh = e - 1;
      m = m << sh;
      e = e - sh;
      r.lat = r.lat + sh;
    end
    q  = m >> 2;
    g  = m[1];
    st = m[0];
    up = g & (st | q[0]);
    q  = q + 64'(up);
    if (q >= 64'd16777216) begin
      q = q >> 1;
      e = e + 1;
    end
    if (q < 64'd8388608) begin
      r.res = {sg, 8'd0, q[22:0]};
      r.unf = 1'b1;
    end else if (e >= 255) begin
      r.res = {sg, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else begin
      r.res = {sg, 8'(e), q[22:0]};
    end
    return r;
  endfunction

  // Present one operand, queue its expectation, optionally keep in_valid high with junk while busy
  task automatic issue(input logic sg, input logic [7:0] ex, input logic [26:0] mn, input int hold);
    exp_t x;
    int   w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    sign_in  = sg;
    exp_in   = ex;
    mant_in  = mn;
    in_valid = 1'b1;
    x        = ref_model(sg, ex, mn);
    x.cap    = edge_cnt + 1;
    sb.push_back(x);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      sign_in = 1'($urandom);
      exp_in  = 8'($urandom_range(1, 254));
      mant_in = 27'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare every presented result against the oldest expectation
  always @(negedge clk) begin
    if (res && out_valid) begin
      chk("pulse_width", 64'(prev_ov), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        chk("result", 64'(result), 64'(cur.res));
        chk("ovf", 64'(ovf), 64'(cur.ovf));
        chk("unf", 64'(unf), 64'(cur.unf));
        chk("latency", 64'(edge_cnt - cur.cap), 64'(cur.lat));
      end
    end
    prev_ov <= out_valid;
  end

  initial begin
    logic       rs;
    logic [7:0] re;
    logic [26:0] rm;
    int          mode;

    res      = 1'b0;
    in_valid = 1'b0;
    sign_in  = 1'b0;
    exp_in   = 8'd0;
    mant_in  = 27'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_unf", 64'(unf), 64'd0);
    res = 1'b1;
    @(negedge clk);

    // directed cases
    issue(1'b0, 8'd127, 27'h2000000, 0);
    issue(1'b0, 8'd127, 27'h4000000, 0);
    issue(1'b0, 8'd127, 27'h0400000, 3);
    issue(1'b0, 8'd127, 27'h2000006, 0);
    issue(1'b0, 8'd127, 27'h2000002, 3);
    issue(1'b0, 8'd127, 27'h3FFFFFE, 0);
    issue(1'b0, 8'd254, 27'h4000000, 2);
    issue(1'b0, 8'd3,   27'h0100000, 0);
    issue(1'b1, 8'd127, 27'h0000000, 3);
    issue(1'b0, 8'd200, 27'h0000001, 0);
    issue(1'b1, 8'd1,   27'h1FFFFFE, 0);
    issue(1'b0, 8'd254, 27'h3FFFFFF, 1);
    issue(1'b0, 8'd1,   27'h0000003, 0);

    // reset two cycles into a three-shift operation
    issue(1'b0, 8'd127, 27'h0400000, 0);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags", 64'({ovf, unf}), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    repeat (10) @(negedge clk);

    // randomized operands
    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 5));
      rs   = 1'($urandom);
      case (int'($urandom_range(0, 2)))
        0:       re = 8'($urandom_range(1, 6));
        1:       re = 8'($urandom_range(248, 254));
        default: re = 8'($urandom_range(1, 254));
      endcase
      case (mode)
        0:       rm = 27'($urandom) | 27'h4000000;
        1:       rm = (27'($urandom) & 27'h1FFFFFF) | 27'h2000000;
        2:       rm = 27'($urandom) >> $urandom_range(1, 26);
        3:       rm = 27'd0;
        4:       rm = 27'h3FFFFF8 | 27'($urandom_range(0, 7));
        default: rm = 27'($urandom);
      endcase
      issue(rs, re, rm, int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
